// File: rtl/kl_pkg.sv
// Shared KL bus definitions: widths, transfer-size encodings and the
// response payload carried from a target back to the initiator.
package kl_pkg;
    localparam int KL_ADDR_W  = 48;
    localparam int KL_DATA_W  = 64;
    localparam int KL_SRCID_W = 5;

    localparam logic [2:0] KL_SIZE_B = 3'd0;
    localparam logic [2:0] KL_SIZE_H = 3'd1;
    localparam logic [2:0] KL_SIZE_W = 3'd2;
    localparam logic [2:0] KL_SIZE_D = 3'd3;

    typedef struct packed {
        logic [KL_DATA_W-1:0]  rdata;
        logic [2:0]            size;
        logic [KL_SRCID_W-1:0] dstid;
    } kl_resp_t;
endpackage

// File: rtl/kl_fifo.sv
// Small synchronous FIFO with occupancy count. A push into a full FIFO is
// taken when a pop happens in the same cycle. The head reads as zero when
// the FIFO is empty, so downstream outputs are clean after reset.
module kl_fifo
    import kl_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = kl_resp_t,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              pop_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? T'('0) : mem[rd_ptr];

    // Payload storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/kl_ram.sv
// KL bus SRAM target: posted byte-masked writes, 2-cycle reads through an
// S1 stage into a 3-entry response FIFO, responses in request order.
// Optional build macro KL_RAM_RANGE_CHECK_EN: out-of-window requests are
// flagged; flagged writes are dropped and flagged reads return DEADBEEF.
// Without it, upper address bits are ignored and the address wraps.
module kl_ram
    import kl_pkg::*;
#(
    parameter int                   DEPTH_LOG2 = 12,
    parameter logic [KL_ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KL_ADDR_W-1:0]  req_addr,
    input  logic                  req_wen,
    input  logic [KL_DATA_W-1:0]  req_wdata,
    input  logic [7:0]            req_wmask,
    input  logic [2:0]            req_size,
    input  logic [KL_SRCID_W-1:0] req_srcid,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [KL_DATA_W-1:0]  resp_rdata,
    output logic [2:0]            resp_size,
    output logic [KL_SRCID_W-1:0] resp_dstid,
    output logic                  resp_valid,
    input  logic                  resp_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [KL_DATA_W-1:0] BAD_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic [KL_DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept, rd_acc, wr_acc, out_of_range;
    logic                  s1_valid;
    kl_resp_t              s1_data, head;
    logic [1:0]            fifo_count;
    logic                  fifo_empty, fifo_full;

    assign idx    = req_addr[DEPTH_LOG2+2:3];
    assign accept = req_valid & req_ready;
    assign rd_acc = accept & ~req_wen;
    assign wr_acc = accept & req_wen & ~out_of_range;

`ifdef KL_RAM_RANGE_CHECK_EN
    localparam logic [KL_ADDR_W-1:0] RAM_BYTES = KL_ADDR_W'(8) << DEPTH_LOG2;
    assign out_of_range = (req_addr < BASE_ADDR) || (req_addr >= BASE_ADDR + RAM_BYTES);
`else
    logic unused_addr;
    assign out_of_range = 1'b0;
    assign unused_addr  = ^{req_addr[KL_ADDR_W-1:DEPTH_LOG2+3], req_addr[2:0]};
`endif

    // Slot reservation counts the S1 entry, so every S1 result always fits
    // in the FIFO and ready never depends on this cycle's resp_ready.
    assign req_ready = ({1'b0, fifo_count} + {2'b00, s1_valid}) < 3'd3;

    // Byte-masked posted write into the array.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < 8; i++) begin
                if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Synchronous array read plus request echo into S1.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            s1_data.rdata <= out_of_range ? BAD_DATA : mem[idx];
            s1_data.size  <= req_size;
            s1_data.dstid <= req_srcid;
        end
    end

    // S1 occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= rd_acc;
    end

    kl_fifo #(.DEPTH(3), .T(kl_resp_t)) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (s1_data),
        .pop       (resp_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign resp_valid = ~fifo_empty;
    assign resp_rdata = head.rdata;
    assign resp_size  = head.size;
    assign resp_dstid = head.dstid;

    logic unused_full;
    assign unused_full = fifo_full;
endmodule
